// File: rtl/melody_tone_gen_if.sv
// Sample-request handshake between the tone source and the codec.
// The tone source is the master; the codec side is the slave.
interface melody_tone_gen_if #(
   parameter int SAMPLE_W = 32
);
   logic                sample_req;
   logic [SAMPLE_W-1:0] sample_out;
   logic                sample_valid;

   modport master (
      input  sample_req,
      output sample_out,
      output sample_valid
   );

   modport slave (
      output sample_req,
      input  sample_out,
      input  sample_valid
   );
endinterface

// File: rtl/melody_tone_gen.sv
// Square-wave tone source: prioritised live keys or a sequenced
// melody RAM with per-entry beats, rests, loop and stop.
module melody_tone_gen #(
   parameter int CLK_HZ     = 50000000,
   parameter int NOTE_W     = 20,
   parameter int SAMPLE_W   = 32,
   parameter int AMPLITUDE  = 10000000,
   parameter int NUM_KEYS   = 5,
   parameter int SONG_DEPTH = 64,
   parameter int DUR_W      = 4,
   parameter int BEAT_TICKS = 6250000,
   localparam int ADDR_W    = $clog2(SONG_DEPTH)
) (
   input  logic                   CLOCK_50,
   input  logic                   resetn,
   input  logic [NUM_KEYS-1:0]    key_on,
   input  logic [NUM_KEYS*NOTE_W-1:0] key_period,
   input  logic                   play_start,
   input  logic                   play_stop,
   input  logic                   loop_en,
   input  logic [ADDR_W:0]        song_len,
   input  logic                   wr_en,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [NOTE_W-1:0]      wr_period,
   input  logic [DUR_W-1:0]       wr_beats,
   melody_tone_gen_if.master      aud,
   output logic                   playing,
   output logic                   song_done,
   output logic [ADDR_W-1:0]      cur_index
);

   localparam int BT_W = $clog2(BEAT_TICKS + 1);
   localparam logic [BT_W-1:0] TICK_RELOAD = BT_W'(BEAT_TICKS - 1);
   localparam logic [SAMPLE_W-1:0] POS_AMP = SAMPLE_W'(AMPLITUDE);
   localparam logic [SAMPLE_W-1:0] NEG_AMP = SAMPLE_W'(-AMPLITUDE);

   typedef enum logic [2:0] {
      IDLE, FETCH, LATCH, HOLD, ADVANCE
   } state_t;

   state_t state_q, state_d;

   logic [NOTE_W+DUR_W-1:0] ram [SONG_DEPTH];
   logic [NOTE_W+DUR_W-1:0] rd_q;
   logic [NOTE_W-1:0] rd_per;
   logic [DUR_W-1:0]  rd_beats;

   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W:0]   idx_inc;
   logic [NOTE_W-1:0] per_q, per_d;
   logic [BT_W-1:0]   tick_q, tick_d;
   logic [DUR_W-1:0]  num_q, num_d;
   logic              done_d;
   logic              eos;

   logic [NOTE_W-1:0] key_per;
   logic [NOTE_W-1:0] sel_per;
   logic              silent;
   logic [NOTE_W-1:0] cnt_q;
   logic              phase_q;

   assign rd_per   = rd_q[DUR_W +: NOTE_W];
   assign rd_beats = rd_q[DUR_W-1:0];
   assign idx_inc  = {1'b0, idx_q} + (ADDR_W+1)'(1);
   assign cur_index = idx_q;

   // Melody RAM: synchronous write, registered read of the current index.
   always_ff @(posedge CLOCK_50) begin
      if (wr_en) ram[wr_addr] <= {wr_period, wr_beats};
      rd_q <= ram[idx_q];
   end

   // Sequencer next state; stop beats start, start restarts from 0.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      per_d   = per_q;
      tick_d  = tick_q;
      num_d   = num_q;
      done_d  = 1'b0;
      eos     = 1'b0;
      if (play_stop) begin
         state_d = IDLE;
         idx_d   = '0;
      end else if (play_start && state_q == IDLE && song_len == '0) begin
         done_d = 1'b1;
      end else if (play_start) begin
         state_d = FETCH;
         idx_d   = '0;
         per_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            FETCH: begin
               state_d = LATCH;
            end
            LATCH: begin
               if (rd_beats == '0) begin
                  eos = 1'b1;
               end else begin
                  per_d   = rd_per;
                  tick_d  = TICK_RELOAD;
                  num_d   = rd_beats - DUR_W'(1);
                  state_d = HOLD;
               end
            end
            HOLD: begin
               if (tick_q != '0) begin
                  tick_d = tick_q - BT_W'(1);
               end else if (num_q != '0) begin
                  num_d  = num_q - DUR_W'(1);
                  tick_d = TICK_RELOAD;
               end else begin
                  state_d = ADVANCE;
               end
            end
            ADVANCE: begin
               if (idx_inc < song_len) begin
                  idx_d   = idx_inc[ADDR_W-1:0];
                  state_d = FETCH;
               end else begin
                  eos = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
         if (eos) begin
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = loop_en ? FETCH : IDLE;
         end
      end
   end

   // Sequencer registers; playing follows the registered state.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         per_q     <= '0;
         tick_q    <= '0;
         num_q     <= '0;
         song_done <= 1'b0;
         playing   <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         per_q     <= per_d;
         tick_q    <= tick_d;
         num_q     <= num_d;
         song_done <= done_d;
         playing   <= (state_d != IDLE);
      end
   end

   // Lowest-index asserted key wins.
   always_comb begin
      key_per = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (key_on[i]) key_per = key_period[i*NOTE_W +: NOTE_W];
      end
   end

   assign sel_per = playing ? per_q : key_per;
   assign silent  = (sel_per == '0);

   // Half-period down-counter; new periods only load on expiry.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else if (!silent) begin
         if (cnt_q == '0) begin
            cnt_q   <= sel_per;
            phase_q <= ~phase_q;
         end else begin
            cnt_q <= cnt_q - NOTE_W'(1);
         end
      end
   end

   // One sample per request, held between strobes.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         aud.sample_out   <= '0;
         aud.sample_valid <= 1'b0;
      end else begin
         aud.sample_valid <= aud.sample_req;
         if (aud.sample_req) begin
            if (silent)       aud.sample_out <= '0;
            else if (phase_q) aud.sample_out <= POS_AMP;
            else              aud.sample_out <= NEG_AMP;
         end
      end
   end

endmodule

// File: doc/melody_tone_gen.md
Name: melody_tone_gen

Overview:
Parametrised square-wave tone source for the audio path. It plays live notes from NUM_KEYS key inputs, with fixed priority, or sequences a loadable melody RAM with per-entry durations, rests, loop and stop. It produces signed samples on the codec's sample-request handshake. It sits between game control (start/gameover) and the Audio_Controller output-mix adders.

Parameters:
CLK_HZ, 50000000, system clock frequency; documentation only, tempo derives from BEAT_TICKS.
NOTE_W, 20, half-period count width in clocks.
SAMPLE_W, 32, output sample width, two's complement.
AMPLITUDE, 10000000, output magnitude; must be below 2^(SAMPLE_W-1).
NUM_KEYS, 5, number of live-play key inputs.
SONG_DEPTH, 64, melody RAM entries; ADDR_W = clog2(SONG_DEPTH).
DUR_W, 4, beats-per-entry width.
BEAT_TICKS, 6250000, clocks per beat (1/8 s at 50 MHz).

Ports:
CLOCK_50  in  1  system clock
resetn  in  1  asynchronous active-low reset
key_on  in  NUM_KEYS  live key levels; bit 0 has highest priority
key_period  in  NUM_KEYS*NOTE_W  half-period per key; key i occupies bits [i*NOTE_W +: NOTE_W]
play_start  in  1  single-cycle pulse; start the melody at index 0
play_stop  in  1  single-cycle pulse; abort the melody
loop_en  in  1  level; wrap to index 0 at end of song
song_len  in  ADDR_W+1  number of valid entries (0..SONG_DEPTH)
wr_en  in  1  melody RAM write strobe
wr_addr  in  ADDR_W  write address
wr_period  in  NOTE_W  entry half-period; 0 = rest
wr_beats  in  DUR_W  entry duration in beats; 0 = end marker
sample_req  in  1  codec ready (audio_out_allowed & audio_in_available)
sample_out  out  SAMPLE_W  signed sample
sample_valid  out  1  one-cycle strobe, one cycle after sample_req
playing  out  1  high while the sequencer is not IDLE
song_done  out  1  one-cycle pulse at each end of song
cur_index  out  ADDR_W  entry currently sounding

Behaviour:
- Reset values (async, all outputs): sample_out=0, sample_valid=0, playing=0, song_done=0, cur_index=0; state=IDLE; tone counter=0; phase=0. RAM contents are not reset.
- RAM: one synchronous write port and one synchronous read port. Read data is available the cycle after the address is presented.
- States and transitions:
  - IDLE: on play_start go to FETCH with index=0. If song_len=0, instead pulse song_done the next cycle and stay in IDLE.
  - FETCH: present index to the RAM.
  - LATCH: capture period and beats. If beats=0, treat as end of song. Otherwise reload the beat counter to BEAT_TICKS-1 and the beat count to beats-1, then go to HOLD.
  - HOLD: beat counter decrements every clock. At 0 with beat count 0, go to ADVANCE; at 0 otherwise, decrement beat count and reload the beat counter.
  - ADVANCE: if index+1 < song_len, increment index and go to FETCH. Otherwise it is end of song.
- End of song: pulse song_done. If loop_en, index=0 and go to FETCH; else go to IDLE.
- Note duration: exactly beats*BEAT_TICKS cycles in HOLD, plus 3 overhead cycles per entry (ADVANCE, FETCH, LATCH).
- play_stop in any state: go to IDLE, index=0, no song_done.
- play_start while not IDLE restarts at index 0.
- play_stop and play_start in the same cycle: stop wins.
- Writes during playback are allowed. A write to the sounding entry takes effect on that entry's next fetch.
- Tone source selection:
  - playing=1: the latched entry period.
  - Otherwise: the lowest-index asserted key's period.
  - No key asserted: silence.
- Tone generator: down-counter; at 0, reload with the selected period and toggle phase. A period change therefore takes effect at the next counter expiry (glitch-free). Selected period 0 = silence, with counter and phase held.
- Sample generation: on sample_req, the next cycle gives sample_valid=1 and sample_out = +AMPLITUDE if phase=1, -AMPLITUDE if phase=0, 0 if silent. sample_out holds its value between strobes.
- playing and cur_index are registered, updated with the state.

Test Plan:
- Key priority. Bench params: BEAT_TICKS=10. key_on=5'b00110, key_period[1]=4, key_period[2]=7. Hold sample_req=1 -> phase toggles every 5 clocks (key 1); sample_out alternates +/-10000000. Drop key_on to 0 -> sample_out=0 on the next strobe.
- Melody timing. Write {3,2},{0,1},{5,1}; song_len=3; pulse play_start.
  - playing rises 1 cycle later.
  - Period-3 tone starts 3 cycles after play_start.
  - Entry 0 lasts 20 cycles.
  - Entry 1 gives sample_out=0 for 10 cycles.
  - song_done pulses once, then playing=0.
- End marker and loop. Entry 1 beats=0, loop_en=1 -> only entry 0 sounds. song_done pulses at every wrap; cur_index returns to 0 each time.
- Stop/start collision. Assert both mid-HOLD -> IDLE, playing=0, no song_done. Then play_start alone -> restarts at index 0.
- Empty song and reset. song_len=0 with play_start -> song_done one cycle later, playing stays 0. Assert resetn=0 mid-HOLD -> all outputs 0 immediately, asynchronously. RAM contents persist after reset.
